// File: rtl/s2p_in.sv
// s2p_in: stereo serial-to-parallel deserializer with frame-error and zero-run detection
module s2p_in #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int ZERO_RUN    = 800
) (
  input  logic             SCLK,
  input  logic             CLR,
  input  logic             EN,
  input  logic             DCLK,
  input  logic             FRAME,
  input  logic             INPUTL,
  input  logic             INPUTR,
  output logic [WIDTH-1:0] DATA_L,
  output logic [WIDTH-1:0] DATA_R,
  output logic             InReady,
  output logic             FRAME_ERR,
  output logic             ZERO_DET
);
  localparam int ZW = $clog2(ZERO_RUN + 1);
  localparam logic [4:0] LAST = 5'(WIDTH - 1);
  localparam logic [ZW-1:0] ZMAX = ZW'(ZERO_RUN);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q;
  logic [4*SYNC_STAGES-1:0] sync_q;
  logic dclk_q, dclk_s, frame_s, inl_s, inr_s, rise, last, zero;
  logic [4:0] bitcnt_q;
  logic [WIDTH-1:0] sr_l_q, sr_r_q, nxt_l, nxt_r;
  logic [ZW-1:0] zcnt_q, zcnt_d;
  // all four pins share one chain so they stay mutually aligned
  assign {dclk_s, frame_s, inl_s, inr_s} = sync_q[4*SYNC_STAGES-1 -: 4];
  always_comb begin
    rise   = dclk_s & ~dclk_q & EN;
    nxt_l  = {sr_l_q[WIDTH-2:0], inl_s};
    nxt_r  = {sr_r_q[WIDTH-2:0], inr_s};
    last   = rise & ~frame_s & (state_q == SHIFT) & (bitcnt_q == LAST);
    zero   = ~|{nxt_l, nxt_r};
    zcnt_d = !zero ? '0 : (zcnt_q == ZMAX) ? zcnt_q : zcnt_q + 1'b1;
  end
  always_ff @(posedge SCLK or posedge CLR) begin
    if (CLR) begin
      sync_q    <= '0;
      dclk_q    <= 1'b0;
      state_q   <= IDLE;
      bitcnt_q  <= '0;
      sr_l_q    <= '0;
      sr_r_q    <= '0;
      zcnt_q    <= '0;
      DATA_L    <= '0;
      DATA_R    <= '0;
      InReady   <= 1'b0;
      FRAME_ERR <= 1'b0;
      ZERO_DET  <= 1'b0;
    end else begin
      sync_q    <= {sync_q[4*SYNC_STAGES-5:0], DCLK, FRAME, INPUTL, INPUTR};
      dclk_q    <= dclk_s;
      InReady   <= last;
      FRAME_ERR <= rise & frame_s & (state_q == SHIFT);
      if (rise & frame_s) begin
        sr_l_q   <= WIDTH'(inl_s);
        sr_r_q   <= WIDTH'(inr_s);
        bitcnt_q <= 5'd1;
        state_q  <= SHIFT;
      end else if (rise & (state_q == SHIFT)) begin
        sr_l_q   <= nxt_l;
        sr_r_q   <= nxt_r;
        bitcnt_q <= bitcnt_q + 5'd1;
        state_q  <= last ? IDLE : SHIFT;
      end
      if (last) begin
        DATA_L   <= nxt_l;
        DATA_R   <= nxt_r;
        zcnt_q   <= zcnt_d;
        ZERO_DET <= zcnt_d == ZMAX;
      end
    end
  end
endmodule

// File: tb/tb_s2p_in.sv
// tb_s2p_in: table-driven frames with a scoreboard of expected sample pairs
module tb_s2p_in;
  localparam int W = 16;
  logic SCLK = 0, CLR = 0, EN = 1, DCLK = 0, FRAME = 0, INPUTL = 0, INPUTR = 0;
  logic [W-1:0] DATA_L, DATA_R;
  logic InReady, FRAME_ERR, ZERO_DET;
  int errors = 0, checks = 0, rc = 0, fe = 0, lat = 0;
  logic prev_ir = 0;
  typedef struct {logic [W-1:0] l, r; logic z;} vec_t;
  vec_t q[$];
  vec_t tbl[16];
  s2p_in #(.WIDTH(W), .SYNC_STAGES(2), .ZERO_RUN(4)) dut (
    .SCLK(SCLK), .CLR(CLR), .EN(EN), .DCLK(DCLK), .FRAME(FRAME),
    .INPUTL(INPUTL), .INPUTR(INPUTR), .DATA_L(DATA_L), .DATA_R(DATA_R),
    .InReady(InReady), .FRAME_ERR(FRAME_ERR), .ZERO_DET(ZERO_DET)
  );
  always #5 SCLK = ~SCLK;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  always @(negedge SCLK) begin
    vec_t e;
    if (FRAME_ERR) fe++;
    if (InReady) begin
      rc++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_inready: got L=%h R=%h want no pulse", DATA_L, DATA_R);
      end else begin
        e = q.pop_front();
        if ({DATA_L, DATA_R, ZERO_DET, prev_ir} !== {e.l, e.r, e.z, 1'b0}) begin
          errors++;
          $display("FAIL frame_out: got L=%h R=%h Z=%b wide=%b want L=%h R=%h Z=%b wide=0",
                   DATA_L, DATA_R, ZERO_DET, prev_ir, e.l, e.r, e.z);
        end
      end
    end
    prev_ir = InReady;
  end
  task automatic send_bit(input logic f, input logic l, input logic r, output int lt);
    FRAME = f; INPUTL = l; INPUTR = r;
    repeat (8) @(negedge SCLK);
    DCLK = 1; lt = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge SCLK);
      if (InReady && lt == 0) lt = i;
    end
    DCLK = 0;
  endtask
  task automatic send_word(input logic [W-1:0] l, input logic [W-1:0] r, input int n, output int lt);
    for (int i = 0; i < n; i++) send_bit(i == 0, l[W-1-i], r[W-1-i], lt);
  endtask
  task automatic send_frame(input vec_t v);
    int lt;
    q.push_back(v);
    send_word(v.l, v.r, W, lt);
  endtask
  initial begin
    for (int n = 0; n < 10; n++) tbl[n] = '{16'(n), ~16'(n), 1'b0};
    tbl[10] = '{16'h0, 16'h0, 1'b0};
    tbl[11] = '{16'h0, 16'h0, 1'b0};
    tbl[12] = '{16'h0, 16'h0, 1'b0};
    tbl[13] = '{16'h0, 16'h0, 1'b1};
    tbl[14] = '{16'h0, 16'h0, 1'b1};
    tbl[15] = '{16'h0, 16'h1, 1'b0};
    #1 CLR = 1;
    repeat (6) begin
      @(negedge SCLK);
      {DCLK, FRAME, INPUTL, INPUTR} = 4'($urandom);
    end
    chk("rst_data_l", 32'(DATA_L), 0);
    chk("rst_data_r", 32'(DATA_R), 0);
    chk("rst_inready", 32'(InReady), 0);
    chk("rst_frame_err", 32'(FRAME_ERR), 0);
    chk("rst_zero_det", 32'(ZERO_DET), 0);
    @(negedge SCLK);
    {DCLK, FRAME, INPUTL, INPUTR} = 4'b0;
    repeat (3) @(negedge SCLK);
    CLR = 0;
    for (int i = 0; i < 3 * W; i++) send_bit(1'b0, 1'($urandom), 1'($urandom), lat);
    chk("idle_no_ready", 32'(rc), 0);
    q.push_back('{16'h8001, 16'h7FFE, 1'b0});
    send_word(16'h8001, 16'h7FFE, W, lat);
    chk("latency", 32'(lat == 3 || lat == 4), 1);
    chk("single_count", 32'(rc), 1);
    for (int i = 0; i < 16; i++) send_frame(tbl[i]);
    repeat (20) @(negedge SCLK);
    chk("b2b_no_frame_err", 32'(fe), 0);
    chk("table_count", 32'(rc), 17);
    send_word(16'hFFFF, 16'hFFFF, 7, lat);
    send_frame('{16'h1234, 16'hABCD, 1'b0});
    repeat (20) @(negedge SCLK);
    chk("frame_err_count", 32'(fe), 1);
    chk("err_ready_count", 32'(rc), 18);
    EN = 0;
    send_word(16'hBEEF, 16'hCAFE, W, lat);
    EN = 1;
    repeat (20) @(negedge SCLK);
    chk("en_low_count", 32'(rc), 18);
    chk("en_low_hold", 32'(DATA_L), 32'h1234);
    for (int i = 0; i < 3; i++) send_frame('{16'h0, 16'h0, 1'b0});
    send_word(16'hFFFF, 16'hFFFF, 9, lat);
    CLR = 1;
    repeat (2) @(negedge SCLK);
    chk("clr_data_l", 32'(DATA_L), 0);
    chk("clr_data_r", 32'(DATA_R), 0);
    chk("clr_zero_det", 32'(ZERO_DET), 0);
    CLR = 0;
    repeat (4) @(negedge SCLK);
    send_frame('{16'h0, 16'h0, 1'b0});
    send_frame('{16'h5A5A, 16'hA5A5, 1'b0});
    repeat (20) @(negedge SCLK);
    chk("final_queue_empty", 32'(q.size()), 0);
    chk("final_count", 32'(rc), 23);
    chk("final_frame_err", 32'(fe), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
